router_ingress_fifo: RTL and testbench

//   Ingress buffer for the 4-port simple router. Accepts {addr,data} words on a

---
 rtl/router_ingress_fifo.sv | 236 +++++++++++++++++++++++
 tb/tb_router_ingress_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/router_ingress_fifo.sv
// -----------------------------------------------------------------------------
// router_ingress_fifo
//
// Ingress buffer for the 4-port simple router. Upstream {addr,data} words
// arrive on a valid/ready handshake and are queued in a DEPTH-entry FIFO.
// Unless out_stall is high, one word per cycle drains into the router's
// din/din_en/addr inputs. Those inputs are driven straight from flops, so
// the router never sees glitches. When nothing is popped they are forced
// to zero, which is how the router recognises an idle cycle.
//
// Optional feature macro: ROUTER_STATS_EN
//   defined   : the stat_cnt port exists. It holds four saturating
//               per-destination counters of popped words.
//   undefined : no stat_cnt port and no counter logic.
//
// Parameters
//   DATA_WIDTH : payload width. It must match the router's DATA_WIDTH.
//   DEPTH      : number of FIFO entries. Must be a power of 2 and >= 2.
//   CNT_WIDTH  : width of each per-destination counter. Used only when
//                ROUTER_STATS_EN is defined.
//
// Ports
//   clk       : clock; all state changes on the rising edge
//   resetn    : asynchronous-assert, active-low reset
//   in_data   : upstream payload
//   in_addr   : upstream destination port (0..3)
//   in_valid  : upstream word is valid
//   in_ready  : FIFO can accept a word; push = in_valid & in_ready
//   out_stall : 1 = do not pop this cycle
//   din       : registered payload to the router
//   din_en    : registered payload-valid to the router
//   addr      : registered destination to the router
//   level     : current occupancy (0..DEPTH)
//   stat_cnt  : [k*CNT_WIDTH +: CNT_WIDTH] = number of words sent to port k
//               (present only with ROUTER_STATS_EN)
// -----------------------------------------------------------------------------

// Occupancy safety checker. It has no functional outputs and only observes
// the FIFO control terms.
module router_ingress_fifo_chk #(
    parameter int DEPTH = 4,
    parameter int LW    = 3
) (
    input logic          clk,
    input logic          resetn,
    input logic          push_s,
    input logic          pop_s,
    input logic [LW-1:0] level_q
);
    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(push_s && (level_q == LW'(DEPTH))));

    a_no_underflow: assert property (@(posedge clk) disable iff (!resetn)
        !(pop_s && (level_q == {LW{1'b0}})));
endmodule

module router_ingress_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [1:0]              in_addr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    out_stall,
    output logic [DATA_WIDTH-1:0]   din,
    output logic                    din_en,
    output logic [1:0]              addr,
    output logic [$clog2(DEPTH):0]  level
`ifdef ROUTER_STATS_EN
    ,
    output logic [4*CNT_WIDTH-1:0]  stat_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);      // pointer width
    localparam int LW = PW + 1;             // level width (0..DEPTH)
    localparam int EW = DATA_WIDTH + 2;     // stored entry {addr,data}

    // Storage (deliberately not reset) and control state
    logic [EW-1:0]          mem_q [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q,  level_d;
    logic [DATA_WIDTH-1:0]  din_q,    din_d;
    logic                   din_en_q, din_en_d;
    logic [1:0]             addr_q,   addr_d;

    logic                   full_s;
    logic                   empty_s;
    logic                   push_s;
    logic                   pop_s;
    logic [EW-1:0]          head_s;
    logic [1:0]             head_addr_s;
    logic [DATA_WIDTH-1:0]  head_data_s;

    // Handshake decode. It uses only the registered level, so a full FIFO
    // refuses a word even in a cycle where it also pops.
    always_comb begin
        full_s      = (level_q == LW'(DEPTH));
        empty_s     = (level_q == {LW{1'b0}});
        push_s      = in_valid & ~full_s;
        pop_s       = ~empty_s & ~out_stall;
        head_s      = mem_q[rd_ptr_q];
        head_addr_s = head_s[EW-1:EW-2];
        head_data_s = head_s[DATA_WIDTH-1:0];
    end

    // Next-state for pointers and occupancy. Pointers wrap naturally
    // because DEPTH is a power of 2.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + {{(LW-1){1'b0}}, 1'b1};
            2'b01:   level_d = level_q - {{(LW-1){1'b0}}, 1'b1};
            default: level_d = level_q;
        endcase
    end

    // Next-state for router-facing outputs. When nothing is popped they
    // are zero, not held.
    always_comb begin
        din_d    = {DATA_WIDTH{1'b0}};
        din_en_d = 1'b0;
        addr_d   = 2'b00;

        if (pop_s) begin
            din_d    = head_data_s;
            din_en_d = 1'b1;
            addr_d   = head_addr_s;
        end else begin
            din_d    = {DATA_WIDTH{1'b0}};
            din_en_d = 1'b0;
            addr_d   = 2'b00;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            level_q  <= {LW{1'b0}};
            din_q    <= {DATA_WIDTH{1'b0}};
            din_en_q <= 1'b0;
            addr_q   <= 2'b00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            din_q    <= din_d;
            din_en_q <= din_en_d;
            addr_q   <= addr_d;
        end
    end

    // FIFO storage write. It has no reset; a read is only allowed once
    // the entry has been written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {in_addr, in_data};
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign in_ready = ~full_s;
    assign din      = din_q;
    assign din_en   = din_en_q;
    assign addr     = addr_q;
    assign level    = level_q;

`ifdef ROUTER_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q [4];
    logic [CNT_WIDTH-1:0] cnt_d [4];

    // Per-destination saturating counters. A counter advances when a pop
    // takes a word headed for its port.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = cnt_q[k];
            if (pop_s && (head_addr_s == k[1:0]) &&
                (cnt_q[k] != {CNT_WIDTH{1'b1}})) begin
                cnt_d[k] = cnt_q[k] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                cnt_d[k] = cnt_q[k];
            end
        end
    end

    // Counter registers. Only reset clears them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= {CNT_WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign stat_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

    router_ingress_fifo_chk #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_chk (
        .clk     (clk),
        .resetn  (resetn),
        .push_s  (push_s),
        .pop_s   (pop_s),
        .level_q (level_q)
    );

endmodule

// File: tb/tb_router_ingress_fifo.sv
// -----------------------------------------------------------------------------
// Self-checking bench for router_ingress_fifo. The reference model keeps a
// queue of pending {addr,data} words plus the expected router-side outputs.
// A compare process checks the DUT against the model on every falling edge.
// Directed sections pin the model with hand-computed literal values, and a
// randomized section follows them.
// -----------------------------------------------------------------------------
module tb_router_ingress_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic               clk;
    logic               resetn;
    logic [DW-1:0]      in_data;
    logic [1:0]         in_addr;
    logic               in_valid;
    logic               in_ready;
    logic               out_stall;
    logic [DW-1:0]      din;
    logic               din_en;
    logic [1:0]         addr;
    logic [LW-1:0]      level;
`ifdef ROUTER_STATS_EN
    logic [4*CW-1:0]    stat_cnt;
`endif

    router_ingress_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_stall (out_stall),
        .din       (din),
        .din_en    (din_en),
        .addr      (addr),
        .level     (level)
`ifdef ROUTER_STATS_EN
        ,
        .stat_cnt  (stat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW+1:0]  mq[$];
    logic [DW-1:0]  exp_din;
    logic [1:0]     exp_addr;
    logic           exp_en;
    int             exp_level;
    int             cnt_m[4];
    bit             chk_en;

    int n_pass;
    int n_total;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    task automatic model_clear();
        mq.delete();
        exp_din   = '0;
        exp_addr  = 2'd0;
        exp_en    = 1'b0;
        exp_level = 0;
        for (int k = 0; k < 4; k++) cnt_m[k] = 0;
    endtask

    // Presents one cycle of inputs and advances the model across the edge.
    // It returns 1 time unit after the rising edge.
    task automatic cycle(input logic v, input logic [1:0] a, input logic [DW-1:0] d,
                         input logic st);
        bit push;
        bit pop;
        logic [DW+1:0] head;
        in_valid  = v;
        in_addr   = a;
        in_data   = d;
        out_stall = st;
        push = v && (mq.size() != DEPTH);
        pop  = (mq.size() != 0) && !st;
        @(posedge clk);
        #1;
        if (pop) begin
            head     = mq.pop_front();
            exp_din  = head[DW-1:0];
            exp_addr = head[DW+1:DW];
            exp_en   = 1'b1;
            if (cnt_m[head[DW+1:DW]] != (1 << CW) - 1) cnt_m[head[DW+1:DW]]++;
        end else begin
            exp_din  = '0;
            exp_addr = 2'd0;
            exp_en   = 1'b0;
        end
        if (push) mq.push_back({a, d});
        exp_level = mq.size();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, '0, 1'b0);
    endtask

    task automatic do_reset();
        chk_en    = 1'b0;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_addr   = 2'd0;
        in_data   = '0;
        out_stall = 1'b0;
        repeat (2) @(posedge clk);
        model_clear();
        @(negedge clk);
        resetn = 1'b1;
        chk_en = 1'b1;
    endtask

    // Compare process: DUT outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("level",    64'(level),    64'(exp_level));
            chk("in_ready", 64'(in_ready), 64'(exp_level != DEPTH));
            chk("din_en",   64'(din_en),   64'(exp_en));
            chk("din",      64'(din),      64'(exp_din));
            chk("addr",     64'(addr),     64'(exp_addr));
`ifdef ROUTER_STATS_EN
            for (int k = 0; k < 4; k++)
                chk("stat_cnt", 64'(stat_cnt[k*CW +: CW]), 64'(cnt_m[k]));
`endif
        end
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        model_clear();
        do_reset();

        // 1: asynchronous reset with three words queued
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'(i), DW'(50 + i), 1'b1);
        chk("t1_level3", 64'(level), 64'd3);
        #2;
        chk_en = 1'b0;
        resetn = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t1_rst_level",    64'(level),    64'd0);
        chk("t1_rst_din_en",   64'(din_en),   64'd0);
        chk("t1_rst_din",      64'(din),      64'd0);
        chk("t1_rst_in_ready", 64'(in_ready), 64'd1);
        model_clear();
        @(negedge clk);
        resetn = 1'b1;
        chk_en = 1'b1;

        // 2: single word, latency of one edge, then idle zeros
        cycle(1'b1, 2'd2, 32'hDEAD_BEEF, 1'b0);
        cycle(1'b0, 2'd0, '0, 1'b0);
        chk("t2_din_en", 64'(din_en), 64'd1);
        chk("t2_addr",   64'(addr),   64'd2);
        chk("t2_din",    64'(din),    64'hDEAD_BEEF);
        cycle(1'b0, 2'd0, '0, 1'b0);
        chk("t2_din_en_off", 64'(din_en), 64'd0);
        chk("t2_din_zero",   64'(din),    64'd0);

        // 3: fill while stalled; the fifth word is held, then the drain is in order
        for (int i = 1; i <= 5; i++) cycle(1'b1, 2'(i), DW'(100 + i), 1'b1);
        chk("t3_level_full", 64'(level),    64'd4);
        chk("t3_in_ready",   64'(in_ready), 64'd0);
        for (int i = 1; i <= 5; i++) begin
            cycle((i <= 2) ? 1'b1 : 1'b0, 2'd1, DW'(105), 1'b0);
            chk("t3_drain_en",  64'(din_en), 64'd1);
            chk("t3_drain_din", 64'(din),    64'(100 + i));
        end
        idle(2);

        // 4: continuous push and pop across pointer wrap
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 2'(i % 4), DW'(i), 1'b0);
            chk("t4_level_le1", 64'(level <= LW'(1)), 64'd1);
            if (i > 0) chk("t4_din", 64'(din), 64'(i - 1));
        end
        cycle(1'b0, 2'd0, '0, 1'b0);
        chk("t4_din_last", 64'(din), 64'd9);
        idle(2);

        // 5: stall mid-drain
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'd3, DW'(200 + i), 1'b1);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 2'd0, '0, 1'b1);
            chk("t5_stall_en",    64'(din_en), 64'd0);
            chk("t5_stall_level", 64'(level),  64'd3);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 2'd0, '0, 1'b0);
            chk("t5_resume_din", 64'(din), 64'(200 + i));
        end
        idle(2);

`ifdef ROUTER_STATS_EN
        // 6: saturating statistics
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 2'd1, DW'(300 + i), 1'b0);
        idle(3);
        chk("t6_cnt0", 64'(stat_cnt[0*CW +: CW]), 64'd0);
        chk("t6_cnt1", 64'(stat_cnt[1*CW +: CW]), 64'd3);
        chk("t6_cnt2", 64'(stat_cnt[2*CW +: CW]), 64'd0);
        chk("t6_cnt3", 64'(stat_cnt[3*CW +: CW]), 64'd0);
`endif

        // Randomized traffic in phases with different valid/stall densities
        for (int ph = 0; ph < 6; ph++) begin
            int vp;
            int sp;
            vp = $urandom_range(20, 95);
            sp = $urandom_range(0, 80);
            for (int i = 0; i < 400; i++) begin
                cycle(($urandom_range(0, 99) < vp) ? 1'b1 : 1'b0,
                      2'($urandom_range(0, 3)), DW'($urandom),
                      ($urandom_range(0, 99) < sp) ? 1'b1 : 1'b0);
            end
        end
        idle(DEPTH + 2);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
